vga_value_label: RTL and testbench

//  Sequential successor to the fixed-text VGA overlay blocks. Renders a

---
 rtl/vga_value_label.sv | 209 ++++++++++++++++++++
 tb/tb_vga_value_label.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_value_label.sv
// Overlay that renders a per-frame sampled fixed-point value, decimal point and 's' unit
// as a segment-style label; the value is BCD-converted and swapped in atomically.
module vga_value_label #(
    parameter int unsigned X0          = 243,
    parameter int unsigned Y0          = 940,
    parameter int unsigned DIGITS      = 2,
    parameter int unsigned FRAC_DIGITS = 1,
    parameter int unsigned VALUE_W     = 8,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic               CLK_VGA,
    input  logic               RESET,
    input  logic [11:0]        VGA_horzCoord,
    input  logic [11:0]        VGA_vertCoord,
    input  logic [VALUE_W-1:0] VALUE,
    output logic               CONDITION,
    output logic               BUSY,
    output logic               OVERFLOW
);

    localparam int unsigned COORD_W   = 12;
    localparam int unsigned CELL_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BCD_D     = (VALUE_W * 3) / 10 + 1;
    localparam int unsigned BCD_N     = (BCD_D > DIGITS) ? BCD_D : DIGITS;
    localparam int unsigned BCD_W     = 4 * BCD_N;
    localparam int unsigned CNT_W     = $clog2(VALUE_W + 1);
    localparam int unsigned INT_CELLS = DIGITS - FRAC_DIGITS;
    localparam int unsigned DP_X      = X0 + 10 * INT_CELLS - 3;
    localparam int unsigned S_X       = X0 + 10 * DIGITS + 8;

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t                  state_q, state_d;
    logic [VALUE_W-1:0]      sh_q, sh_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d, adj_c;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DIGITS-1:0][3:0]  shown_q, shown_d;
    logic                    ovf_q, ovf_d;
    logic                    busy_q;
    logic                    prev_zero_q;
    logic                    zero_c, frame_start_c, upper_nz_c;

    logic [CELL_W-1:0]       cell_q, cell_d;
    logic [2:0]              dx_q, dx_d;
    logic [3:0]              dy_q, dy_d;
    logic                    cell_hit_q, cell_hit_d;
    logic                    dp_hit_q, dp_hit_d;
    logic                    s_hit_q, s_hit_d;
    logic                    cond_q, cond_d;

    logic                    y_in_c, s_in_c;
    logic [1:0]              s_col_c;
    logic [3:0]              s_mask_c;
    logic [3:0]              digit_c;
    logic                    blank_c, lead_c;
    logic [6:0]              segs_c, geo_c;

    assign zero_c        = (VGA_horzCoord == '0) && (VGA_vertCoord == '0);
    assign frame_start_c = zero_c && !prev_zero_q;

    // Conversion FSM: latch, shift-add-3 one bit per cycle, then publish.
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        shown_d    = shown_q;
        ovf_d      = ovf_q;
        adj_c      = bcd_q;
        upper_nz_c = 1'b0;
        for (int unsigned k = 0; k < BCD_N; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) adj_c[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        for (int unsigned k = DIGITS; k < BCD_N; k++) begin
            upper_nz_c = upper_nz_c | (|bcd_q[4*k +: 4]);
        end
        case (state_q)
            IDLE: begin
                if (frame_start_c) begin
                    state_d = CONV;
                    sh_d    = VALUE;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            CONV: begin
                bcd_d = (adj_c << 1) | BCD_W'(sh_q[VALUE_W-1]);
                sh_d  = sh_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = LOAD;
            end
            LOAD: begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    shown_d[i] = bcd_q[4*(DIGITS-1-i) +: 4];
                end
                ovf_d   = upper_nz_c;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage 1: locate the pixel inside a digit cell, the DP or the 's' glyph.
    always_comb begin
        cell_d     = '0;
        dx_d       = '0;
        cell_hit_d = 1'b0;
        y_in_c     = (VGA_vertCoord >= COORD_W'(Y0)) && (VGA_vertCoord <= COORD_W'(Y0 + 10));
        dy_d       = 4'(VGA_vertCoord - COORD_W'(Y0));
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (VGA_horzCoord >= COORD_W'(X0 + 10*i) && VGA_horzCoord <= COORD_W'(X0 + 10*i + 4)) begin
                cell_d     = CELL_W'(i);
                dx_d       = 3'(VGA_horzCoord - COORD_W'(X0 + 10*i));
                cell_hit_d = y_in_c;
            end
        end
        dp_hit_d = (FRAC_DIGITS != 0) && (VGA_horzCoord == COORD_W'(DP_X))
                   && (VGA_vertCoord == COORD_W'(Y0 + 10));
        s_in_c   = y_in_c && (VGA_vertCoord >= COORD_W'(Y0 + 4))
                   && (VGA_horzCoord >= COORD_W'(S_X)) && (VGA_horzCoord <= COORD_W'(S_X + 3));
        s_col_c  = 2'(VGA_horzCoord - COORD_W'(S_X));
        case (dy_d)
            4'd4, 4'd7, 4'd10: s_mask_c = 4'b0110;
            4'd5, 4'd9:        s_mask_c = 4'b1001;
            4'd6:              s_mask_c = 4'b0001;
            4'd8:              s_mask_c = 4'b1000;
            default:           s_mask_c = 4'b0000;
        endcase
        s_hit_d = s_in_c && s_mask_c[s_col_c];
    end

    // Stage 2: segment lookup for the selected cell, with dash and zero blanking.
    always_comb begin
        digit_c = '0;
        blank_c = 1'b0;
        lead_c  = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (shown_q[i] != 4'd0) lead_c = 1'b0;
            if (cell_q == CELL_W'(i)) begin
                digit_c = shown_q[i];
                blank_c = LZ_BLANK && lead_c && (i + 1 < INT_CELLS);
            end
        end
        case (digit_c)
            4'd0:    segs_c = 7'b1111110;
            4'd1:    segs_c = 7'b0110000;
            4'd2:    segs_c = 7'b1101101;
            4'd3:    segs_c = 7'b1111001;
            4'd4:    segs_c = 7'b0110011;
            4'd5:    segs_c = 7'b1011011;
            4'd6:    segs_c = 7'b1011111;
            4'd7:    segs_c = 7'b1110000;
            4'd8:    segs_c = 7'b1111111;
            4'd9:    segs_c = 7'b1111011;
            default: segs_c = 7'b0000000;
        endcase
        if (ovf_q)        segs_c = 7'b0000001;
        else if (blank_c) segs_c = 7'b0000000;
        geo_c[6] = (dy_q == 4'd0);
        geo_c[5] = (dx_q == 3'd4) && (dy_q <= 4'd5);
        geo_c[4] = (dx_q == 3'd4) && (dy_q >= 4'd5);
        geo_c[3] = (dy_q == 4'd10);
        geo_c[2] = (dx_q == 3'd0) && (dy_q >= 4'd5);
        geo_c[1] = (dx_q == 3'd0) && (dy_q <= 4'd5);
        geo_c[0] = (dy_q == 4'd5);
        cond_d   = (cell_hit_q && (|(segs_c & geo_c))) || dp_hit_q || s_hit_q;
    end

    always_ff @(posedge CLK_VGA or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            shown_q     <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            prev_zero_q <= 1'b0;
            cell_q      <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            cell_hit_q  <= 1'b0;
            dp_hit_q    <= 1'b0;
            s_hit_q     <= 1'b0;
            cond_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            shown_q     <= shown_d;
            ovf_q       <= ovf_d;
            busy_q      <= (state_d != IDLE);
            prev_zero_q <= zero_c;
            cell_q      <= cell_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            cell_hit_q  <= cell_hit_d;
            dp_hit_q    <= dp_hit_d;
            s_hit_q     <= s_hit_d;
            cond_q      <= cond_d;
        end
    end

    assign CONDITION = cond_q;
    assign BUSY      = busy_q;
    assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_vga_value_label.sv
// Bench for vga_value_label: directed vector table, hand-written multi-cycle sequences,
// and random values/pixels checked against a glyph-level reference model.
module tb_vga_value_label;

    localparam int X0 = 243;
    localparam int Y0 = 940;
    localparam int DIGITS = 2;
    localparam int FRAC = 1;
    localparam int VW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] hx, vy;
    logic [7:0]  value;
    logic        cond, busy, ovf;

    int n_cmp = 0;
    int n_err = 0;

    string seg_of [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                           "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
    string s_rows [7]  = '{" ## ", "#  #", "#   ", " ## ", "   #", "#  #", " ## "};

    typedef struct {
        int    value;
        int    x;
        int    y;
        int    exp;
        string name;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    vga_value_label dut (
        .CLK_VGA      (clk),
        .RESET        (rst),
        .VGA_horzCoord(hx),
        .VGA_vertCoord(vy),
        .VALUE        (value),
        .CONDITION    (cond),
        .BUSY         (busy),
        .OVERFLOW     (ovf)
    );

    // Label pixel as described by the glyph rules, from the value shown.
    function automatic int model_px(int x, int y, int v);
        int    dy, ux, rel, c, dx, scale, digit;
        int    hit;
        string segs;
        byte   ch;
        if (y < Y0 || y > Y0 + 10) return 0;
        dy = y - Y0;
        ux = X0 + 10 * DIGITS + 8;
        if (x >= ux && x <= ux + 3) begin
            if (dy < 4) return 0;
            ch = s_rows[dy-4][x-ux];
            return (ch == "#") ? 1 : 0;
        end
        if (x == X0 + 10 * (DIGITS - FRAC) - 3 && dy == 10) return 1;
        if (x < X0) return 0;
        rel = x - X0;
        c   = rel / 10;
        dx  = rel % 10;
        if (c >= DIGITS || dx > 4) return 0;
        if (v > 10**DIGITS - 1) segs = "g";
        else begin
            scale = 10**(DIGITS - 1 - c);
            digit = (v / scale) % 10;
            if (c < DIGITS - FRAC - 1 && (v / scale) == 0) segs = "";
            else segs = seg_of[digit];
        end
        hit = 0;
        for (int k = 0; k < segs.len(); k++) begin
            case (segs[k])
                "a": if (dy == 0) hit = 1;
                "b": if (dx == 4 && dy <= 5) hit = 1;
                "c": if (dx == 4 && dy >= 5) hit = 1;
                "d": if (dy == 10) hit = 1;
                "e": if (dx == 0 && dy >= 5) hit = 1;
                "f": if (dx == 0 && dy <= 5) hit = 1;
                "g": if (dy == 5) hit = 1;
                default: ;
            endcase
        end
        return hit;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic probe(input int x, input int y, output int c);
        hx = 12'(x);
        vy = 12'(y);
        tick();
        tick();
        c = int'(cond);
    endtask

    // Present a frame start and wait out the conversion; optionally change VALUE mid-way.
    task automatic frame(input int v, input int mid_v, output int cycles);
        value = 8'(v);
        hx = 12'd7; vy = 12'd7;
        tick();
        hx = 12'd0; vy = 12'd0;
        tick();
        hx = 12'd7; vy = 12'd7;
        cycles = 0;
        while (busy && cycles < 50) begin
            cycles++;
            if (cycles == 3 && mid_v >= 0) value = 8'(mid_v);
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c, cyc, v, x, y, cur;

        // Label vectors: value to display, probe pixel, expected CONDITION.
        vecs.push_back('{4,   253, 945, 1, "v4_f_g"});
        vecs.push_back('{4,   255, 940, 0, "v4_a_off"});
        vecs.push_back('{4,   250, 950, 1, "v4_dp"});
        vecs.push_back('{4,   272, 944, 1, "v4_s_row4"});
        vecs.push_back('{4,   243, 940, 1, "v4_cell0_zero"});
        vecs.push_back('{4,   253, 950, 0, "v4_d_off"});
        vecs.push_back('{4,   245, 945, 0, "v4_zero_no_g"});
        vecs.push_back('{4,   3,   940, 0, "wrap_left"});
        vecs.push_back('{4,   243, 5,   0, "wrap_above"});
        vecs.push_back('{57,  243, 942, 1, "v57_5_f"});
        vecs.push_back('{57,  247, 942, 0, "v57_5_b_off"});
        vecs.push_back('{57,  257, 942, 1, "v57_7_b"});
        vecs.push_back('{150, 245, 945, 1, "v150_dash0"});
        vecs.push_back('{150, 245, 940, 0, "v150_no_a"});
        vecs.push_back('{150, 255, 945, 1, "v150_dash1"});
        vecs.push_back('{150, 250, 950, 1, "v150_dp"});
        vecs.push_back('{12,  245, 945, 0, "v12_1_no_g"});
        vecs.push_back('{12,  247, 942, 1, "v12_1_b"});
        vecs.push_back('{12,  255, 945, 1, "v12_2_g"});
        vecs.push_back('{12,  253, 948, 1, "v12_2_e"});
        vecs.push_back('{12,  257, 948, 0, "v12_2_c_off"});
        vecs.push_back('{99,  243, 950, 1, "v99_d"});
        vecs.push_back('{99,  243, 948, 0, "v99_e_off"});

        // Reset: outputs low throughout, then the zero label appears.
        rst = 1'b1; value = '0; hx = 12'd243; vy = 12'd940;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cond_in_reset", int'(cond), 0);
        end
        check("busy_in_reset", int'(busy), 0);
        check("ovf_in_reset", int'(ovf), 0);
        rst = 1'b0;
        probe(243, 940, c); check("reset_zero_a", c, 1);
        probe(245, 945, c); check("reset_zero_no_g", c, 0);
        probe(250, 950, c); check("reset_dp", c, 1);
        cur = 0;

        // Directed table.
        foreach (vecs[i]) begin
            if (vecs[i].value != cur) begin
                frame(vecs[i].value, -1, cyc);
                check("busy_len", cyc, VW + 1);
                check("overflow_flag", int'(ovf), (vecs[i].value > 99) ? 1 : 0);
                cur = vecs[i].value;
            end
            probe(vecs[i].x, vecs[i].y, c);
            check(vecs[i].name, c, vecs[i].exp);
        end

        // VALUE change between frame starts is not shown until the next frame.
        frame(4, -1, cyc);
        value = 8'd9;
        for (int i = 0; i < 5; i++) tick();
        probe(253, 950, c); check("midframe_still_4", c, 0);
        frame(9, -1, cyc);
        probe(253, 950, c); check("next_frame_shows_9", c, 1);

        // VALUE change during conversion does not disturb the latched value.
        frame(33, 88, cyc);
        check("busy_len_midchange", cyc, VW + 1);
        probe(243, 942, c); check("latched_33_no_f", c, 0);
        probe(243, 940, c); check("latched_33_a", c, 1);

        // Reset on the third BUSY cycle aborts and clears shown value and OVERFLOW.
        frame(200, -1, cyc);
        check("ovf_200", int'(ovf), 1);
        value = 8'd45;
        hx = 12'd7; vy = 12'd7;
        tick();
        hx = 12'd0; vy = 12'd0;
        tick();
        hx = 12'd7; vy = 12'd7;
        tick();
        tick();
        check("busy_before_abort", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_cond", int'(cond), 0);
        check("abort_ovf", int'(ovf), 0);
        tick();
        rst = 1'b0;
        probe(243, 940, c); check("after_abort_a", c, 1);
        probe(245, 945, c); check("after_abort_no_g", c, 0);
        probe(253, 945, c); check("after_abort_frac0", c, 1);
        probe(255, 945, c); check("after_abort_frac_no_g", c, 0);
        check("after_abort_busy", int'(busy), 0);
        cur = 0;

        // Random values and pixels against the reference model.
        for (int r = 0; r < 15; r++) begin
            v = int'($urandom_range(0, 255));
            frame(v, -1, cyc);
            check("rand_busy_len", cyc, VW + 1);
            check("rand_overflow", int'(ovf), (v > 99) ? 1 : 0);
            for (int p = 0; p < 40; p++) begin
                if (p % 10 == 9) begin
                    x = int'($urandom_range(1, 4095));
                    y = int'($urandom_range(1, 4095));
                end else begin
                    x = int'($urandom_range(235, 280));
                    y = int'($urandom_range(935, 955));
                end
                probe(x, y, c);
                check($sformatf("rand_px_v%0d_(%0d,%0d)", v, x, y), c, model_px(x, y, v));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
